// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sharing one single-port register file among NREQ clients,
// with a post-reset init sweep. Optional address range check: RF_ARB_ADDR_CHECK_EN.
module rf_port_arbiter #(
  parameter int              NREQ     = 4,
  parameter int              ABITS    = 7,
  parameter int              DBITS    = 13,
  parameter int              DEPTH    = 16,
  parameter logic [DBITS-1:0] INIT_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0]           req_we,
  input  logic [NREQ*ABITS-1:0]     req_addr,
  input  logic [NREQ*DBITS-1:0]     req_wdata,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic                      rsp_we,
  output logic [DBITS-1:0]          rsp_data,
  output logic                      rsp_err,
  output logic                      init_done,
  output logic                      rf_we,
  output logic [ABITS-1:0]          rf_waddr,
  output logic [DBITS-1:0]          rf_din,
  output logic [ABITS-1:0]          rf_raddr,
  input  logic [DBITS-1:0]          rf_q
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [ABITS-1:0] LAST_IDX = ABITS'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [ABITS-1:0]  init_cnt_q, init_cnt_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    gnt_id, cand;
  logic              gnt_found;
  logic              hs;
  logic              sel_we;
  logic [ABITS-1:0]  sel_addr;
  logic [DBITS-1:0]  sel_wdata;
  logic              sel_oob;
  logic [ABITS-1:0]  addr_hold_q;
  logic [DBITS-1:0]  din_hold_q;
  logic              rsp_vld_q;
  logic [IDW-1:0]    rsp_id_q;
  logic              rsp_we_q;

`ifdef RF_ARB_ADDR_CHECK_EN
  logic rsp_err_q;

  function automatic logic addr_oob(input logic [ABITS-1:0] a);
    return (int'(a) >= DEPTH);
  endfunction
`endif

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = rr_ptr_q + IDW'(k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  assign sel_we    = req_we[gnt_id];
  assign sel_addr  = req_addr[gnt_id*ABITS +: ABITS];
  assign sel_wdata = req_wdata[gnt_id*DBITS +: DBITS];

`ifdef RF_ARB_ADDR_CHECK_EN
  assign sel_oob = addr_oob(sel_addr);
`else
  assign sel_oob = 1'b0;
`endif

  assign hs = gnt_found && (state_q == ST_RUN) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      rr_ptr_q   <= IDW'(NREQ - 1);
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + ABITS'(1);
        if (init_cnt_q == LAST_IDX) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (hs) rr_ptr_d = gnt_id;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Reset gates the RF write and grants so nothing is issued while it is held.
  always_comb begin
    req_ready = '0;
    rf_we     = 1'b0;
    rf_waddr  = addr_hold_q;
    rf_din    = din_hold_q;
    if (!reset) begin
      case (state_q)
        ST_INIT: begin
          rf_we    = 1'b1;
          rf_waddr = init_cnt_q;
          rf_din   = INIT_VAL;
        end
        ST_RUN: begin
          if (gnt_found) begin
            req_ready[gnt_id] = 1'b1;
            rf_we    = sel_we && !sel_oob;
            rf_waddr = sel_addr;
            rf_din   = sel_wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign rf_raddr  = rf_waddr;
  assign init_done = (state_q == ST_RUN);

  always_ff @(posedge clk) begin
    addr_hold_q <= rf_waddr;
    din_hold_q  <= rf_din;
    rsp_id_q    <= gnt_id;
    rsp_we_q    <= sel_we;
  end

  // Response stage: one cycle behind the grant, aligned with the RF's registered q.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_vld_q <= 1'b0;
`ifdef RF_ARB_ADDR_CHECK_EN
      rsp_err_q <= 1'b0;
`endif
    end else begin
      rsp_vld_q <= hs;
`ifdef RF_ARB_ADDR_CHECK_EN
      rsp_err_q <= hs && sel_oob;
`endif
    end
  end

  assign rsp_valid = rsp_vld_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_we    = rsp_we_q;

`ifdef RF_ARB_ADDR_CHECK_EN
  assign rsp_err  = rsp_err_q;
  assign rsp_data = rsp_err_q ? '0 : rf_q;
`else
  assign rsp_err  = 1'b0;
  assign rsp_data = rf_q;
`endif

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: behavioural RF macro, cycle scoreboard, directed and random steps.
module tb_rf_port_arbiter;

  localparam int NREQ  = 4;
  localparam int ABITS = 7;
  localparam int DBITS = 13;
  localparam int DEPTH = 16;
  localparam int IDW   = 2;
  localparam logic [DBITS-1:0] INIT_VAL = '0;
`ifdef RF_ARB_ADDR_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid, req_ready, req_we;
  logic [NREQ*ABITS-1:0] req_addr;
  logic [NREQ*DBITS-1:0] req_wdata;
  logic                  rsp_valid, rsp_we, rsp_err, init_done;
  logic [IDW-1:0]        rsp_id;
  logic [DBITS-1:0]      rsp_data;
  logic                  rf_we;
  logic [ABITS-1:0]      rf_waddr, rf_raddr;
  logic [DBITS-1:0]      rf_din, rf_q;

  rf_port_arbiter #(
    .NREQ(NREQ), .ABITS(ABITS), .DBITS(DBITS), .DEPTH(DEPTH), .INIT_VAL(INIT_VAL)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_we(rsp_we),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .init_done(init_done),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_din(rf_din),
    .rf_raddr(rf_raddr), .rf_q(rf_q)
  );

  always #5 clk = ~clk;

  // Single-port RF macro: no reset, low address bits select the entry.
  logic [DBITS-1:0] rf_mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) rf_mem[i] = DBITS'($urandom);
  always @(posedge clk) begin
    if (rf_we) begin
      rf_mem[int'(rf_waddr) % DEPTH] <= rf_din;
      rf_q <= rf_din;
    end else begin
      rf_q <= rf_mem[int'(rf_raddr) % DEPTH];
    end
  end

  int checks;
  int failures;

  // Reference model state
  int m_mem [DEPTH];
  bit m_init;
  int m_cnt;
  int m_last;
  int m_hold;
  bit p_vld;
  int p_id, p_we, p_data, p_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input bit we, input int addr, input int data);
    req_valid[i] = v;
    req_we[i]    = we;
    req_addr[i*ABITS +: ABITS]  = ABITS'(addr);
    req_wdata[i*DBITS +: DBITS] = DBITS'(data);
  endtask

  task automatic clear_req();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic rand_req();
    for (int i = 0; i < NREQ; i++) begin
      int a;
      a = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, DEPTH - 1));
      set_req(i, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, a, int'($urandom_range(0, 8191)));
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    @(negedge clk);
    if (reset) begin
      chk("reset_rf_we", 32'(rf_we), 0);
      chk("reset_req_ready", 32'(req_ready), 0);
      m_init = 1'b1;
      m_cnt  = 0;
      m_last = NREQ - 1;
      p_vld  = 1'b0;
    end else begin
      chk("rsp_valid", 32'(rsp_valid), 32'(p_vld));
      if (p_vld) begin
        chk("rsp_id", 32'(rsp_id), 32'(p_id));
        chk("rsp_we", 32'(rsp_we), 32'(p_we));
        chk("rsp_data", 32'(rsp_data), 32'(p_data));
        chk("rsp_err", 32'(rsp_err), 32'(p_err));
      end
      chk("init_done", 32'(init_done), 32'(!m_init));
      if (m_init) begin
        chk("init_rf_we", 32'(rf_we), 1);
        chk("init_waddr", 32'(rf_waddr), 32'(m_cnt));
        chk("init_raddr", 32'(rf_raddr), 32'(m_cnt));
        chk("init_din", 32'(rf_din), 32'(INIT_VAL));
        chk("init_ready", 32'(req_ready), 0);
        m_mem[m_cnt] = int'(INIT_VAL);
        m_hold = m_cnt;
        m_cnt++;
        if (m_cnt == DEPTH) m_init = 1'b0;
        p_vld = 1'b0;
      end else begin
        bit found;
        int g, addr, wd;
        bit we, oob, wr;
        found = 1'b0;
        g = 0;
        for (int k = 1; k <= NREQ; k++) begin
          int c;
          c = (m_last + k) % NREQ;
          if (!found && req_valid[c]) begin
            found = 1'b1;
            g = c;
          end
        end
        chk("req_ready", 32'(req_ready), found ? (32'd1 << g) : 32'd0);
        if (found) begin
          addr = int'(req_addr[g*ABITS +: ABITS]);
          wd   = int'(req_wdata[g*DBITS +: DBITS]);
          we   = req_we[g];
          oob  = CHK_EN && (addr >= DEPTH);
          wr   = we && !oob;
          chk("rf_we", 32'(rf_we), 32'(wr));
          chk("rf_raddr", 32'(rf_raddr), 32'(addr));
          if (wr) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(addr));
            chk("rf_din", 32'(rf_din), 32'(wd));
          end
          p_vld  = 1'b1;
          p_id   = g;
          p_we   = we;
          p_err  = oob;
          p_data = oob ? 0 : (we ? wd : m_mem[addr % DEPTH]);
          if (wr) m_mem[addr % DEPTH] = wd;
          m_last = g;
          m_hold = addr;
        end else begin
          chk("idle_rf_we", 32'(rf_we), 0);
          chk("idle_addr_hold", 32'(rf_waddr), 32'(m_hold));
          p_vld = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_hold   = 0;
    reset    = 1'b1;
    clear_req();
    cycle();
    cycle();
    reset = 1'b0;

    // Idle init sweep, then first RUN cycle sees init_done
    repeat (DEPTH) cycle();

    // All four requesters read continuously: rotation 0,1,2,3,...
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, i * 3, 0);
    repeat (8) cycle();
    clear_req();

    // Every entry reads back as the init value
    for (int a = 0; a < DEPTH; a++) begin
      set_req(0, 1'b1, 1'b0, a, 0);
      cycle();
    end
    clear_req();
    cycle();

    // Write then immediate read of the same address
    set_req(1, 1'b1, 1'b1, 5, 'h1ABC);
    cycle();
    set_req(1, 1'b1, 1'b0, 5, 0);
    cycle();
    clear_req();
    cycle();

    // Single requester streaming, then a competitor above it wins next
    set_req(2, 1'b1, 1'b0, 7, 0);
    repeat (3) cycle();
    set_req(3, 1'b1, 1'b0, 8, 0);
    cycle();
    cycle();
    clear_req();
    cycle();

    // Out-of-range write followed by a read of its alias
    set_req(0, 1'b1, 1'b1, 100, 'h0FFF);
    cycle();
    set_req(0, 1'b1, 1'b0, 4, 0);
    cycle();
    clear_req();
    cycle();

    // Reset during the sweep restarts it from entry 0; requests are ignored meanwhile
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (7) begin
      rand_req();
      cycle();
    end
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    repeat (DEPTH) begin
      rand_req();
      cycle();
    end
    clear_req();
    cycle();

    // Random traffic
    repeat (600) begin
      rand_req();
      cycle();
    end
    clear_req();
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
